// File: rtl/io_port_bridge.sv
// io_port_bridge: couples the accumulator processor's 16-bit I/O registers
// to external valid/ready streams. Processor output writes enter a small
// first-word-fall-through FIFO; external input words land in one holding
// register that the processor reads. The processor side never stalls and
// misuse is flagged on err_out_ovf / err_in_unf.
//
// Build option: define IO_BRIDGE_STICKY_ERR_EN for sticky error flags that
// hold until reset or err_clr; otherwise each flag is a one-cycle pulse and
// err_clr has no effect.
module io_port_bridge #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_out_we,
  input  logic [WIDTH-1:0] cpu_out_data,
  input  logic             cpu_in_re,
  output logic [WIDTH-1:0] cpu_in_data,
  output logic             cpu_in_avail,
  output logic             ext_out_valid,
  output logic [WIDTH-1:0] ext_out_data,
  input  logic             ext_out_ready,
  input  logic             ext_in_valid,
  input  logic [WIDTH-1:0] ext_in_data,
  output logic             ext_in_ready,
  input  logic             err_clr,
  output logic             err_out_ovf,
  output logic             err_in_unf
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] in_data_q, in_data_d;
  logic             in_avail_q, in_avail_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             push_c;
  logic             pop_c;
  logic             xfer_c;
  logic             ovf_evt_c;
  logic             unf_evt_c;

  // Handshake qualifiers; a pop frees the slot a full-FIFO write needs.
  always_comb begin
    pop_c     = (count_q != '0) && ext_out_ready;
    push_c    = cpu_out_we && ((count_q < CNT_W'(DEPTH)) || pop_c);
    ovf_evt_c = cpu_out_we && !push_c;
    xfer_c    = ext_in_valid && !in_avail_q && !reset;
    unf_evt_c = cpu_in_re && !in_avail_q;
  end

  // FIFO pointer and occupancy update; power-of-two depth wraps naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
  end

  // Input holding register: load when empty, release on processor read.
  always_comb begin
    in_data_d  = in_data_q;
    in_avail_d = in_avail_q;
    if (xfer_c) begin
      in_data_d  = ext_in_data;
      in_avail_d = 1'b1;
    end else if (cpu_in_re && in_avail_q) begin
      in_avail_d = 1'b0;
    end
  end

`ifdef IO_BRIDGE_STICKY_ERR_EN
  // Sticky flags: a same-cycle event wins over err_clr.
  always_comb begin
    ovf_d = ovf_evt_c || (ovf_q && !err_clr);
    unf_d = unf_evt_c || (unf_q && !err_clr);
  end
`else
  logic err_clr_unused_c;
  assign err_clr_unused_c = err_clr;

  // Pulse flags: high for exactly the cycle after each event.
  always_comb begin
    ovf_d = ovf_evt_c;
    unf_d = unf_evt_c;
  end
`endif

  // Control and status state; synchronous reset discards everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      in_data_q  <= '0;
      in_avail_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      in_data_q  <= in_data_d;
      in_avail_q <= in_avail_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // FIFO storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (!reset && push_c) mem_q[wr_ptr_q] <= cpu_out_data;
  end

  assign ext_out_valid = (count_q != '0);
  assign ext_out_data  = mem_q[rd_ptr_q];
  assign ext_in_ready  = !in_avail_q && !reset;
  assign cpu_in_data   = in_data_q;
  assign cpu_in_avail  = in_avail_q;
  assign err_out_ovf   = ovf_q;
  assign err_in_unf    = unf_q;

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed bench for io_port_bridge: FIFO fill/overflow, full-FIFO
// push+pop, streaming across pointer wrap, input holding register,
// error-flag behaviour for either build, and mid-operation reset.
module tb_io_port_bridge;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             cpu_out_we;
  logic [WIDTH-1:0] cpu_out_data;
  logic             cpu_in_re;
  logic [WIDTH-1:0] cpu_in_data;
  logic             cpu_in_avail;
  logic             ext_out_valid;
  logic [WIDTH-1:0] ext_out_data;
  logic             ext_out_ready;
  logic             ext_in_valid;
  logic [WIDTH-1:0] ext_in_data;
  logic             ext_in_ready;
  logic             err_clr;
  logic             err_out_ovf;
  logic             err_in_unf;

  int n_checks;
  int n_pass;

  io_port_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_out_we   (cpu_out_we),
    .cpu_out_data (cpu_out_data),
    .cpu_in_re    (cpu_in_re),
    .cpu_in_data  (cpu_in_data),
    .cpu_in_avail (cpu_in_avail),
    .ext_out_valid(ext_out_valid),
    .ext_out_data (ext_out_data),
    .ext_out_ready(ext_out_ready),
    .ext_in_valid (ext_in_valid),
    .ext_in_data  (ext_in_data),
    .ext_in_ready (ext_in_ready),
    .err_clr      (err_clr),
    .err_out_ovf  (err_out_ovf),
    .err_in_unf   (err_in_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] exp);
    check({tag, "_valid"}, 32'(ext_out_valid), 32'd1);
    check({tag, "_data"}, 32'(ext_out_data), 32'(exp));
  endtask

  logic [15:0] drain_exp [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1; cpu_out_we = 1'b0; cpu_out_data = '0; cpu_in_re = 1'b0;
    ext_out_ready = 1'b0; ext_in_valid = 1'b0; ext_in_data = '0; err_clr = 1'b0;

    // Reset state
    tick();
    check("rst_valid", 32'(ext_out_valid), 32'd0);
    check("rst_avail", 32'(cpu_in_avail), 32'd0);
    check("rst_in_data", 32'(cpu_in_data), 32'd0);
    check("rst_ovf", 32'(err_out_ovf), 32'd0);
    check("rst_unf", 32'(err_in_unf), 32'd0);
    check("rst_in_ready_low", 32'(ext_in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(ext_in_ready), 32'd1);

    // Fill FIFO with 1..4, sink stalled
    for (int i = 1; i <= 4; i++) begin
      cpu_out_we = 1'b1; cpu_out_data = 16'(i);
      tick();
      chk_head("fill", 16'h0001);
      check("fill_ovf", 32'(err_out_ovf), 32'd0);
    end
    // Fifth write dropped
    cpu_out_data = 16'h0005;
    tick();
    check("ovf_set", 32'(err_out_ovf), 32'd1);
    chk_head("ovf_head", 16'h0001);
    // Flag gone next cycle in either build (err_clr for the sticky one)
    cpu_out_we = 1'b0; err_clr = 1'b1;
    tick();
    check("ovf_clear", 32'(err_out_ovf), 32'd0);
    err_clr = 1'b0;

    // Full FIFO: write 0x00AA while popping
    cpu_out_we = 1'b1; cpu_out_data = 16'h00AA; ext_out_ready = 1'b1;
    tick();
    check("full_pp_ovf", 32'(err_out_ovf), 32'd0);
    cpu_out_we = 1'b0;
    drain_exp[0] = 16'h0002; drain_exp[1] = 16'h0003;
    drain_exp[2] = 16'h0004; drain_exp[3] = 16'h00AA;
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("drain%0d", k), drain_exp[k]);
      tick();
    end
    check("drain_empty", 32'(ext_out_valid), 32'd0);

    // Streaming across pointer wrap, two words in flight
    ext_out_ready = 1'b0; cpu_out_we = 1'b1;
    cpu_out_data = 16'h1000; tick();
    cpu_out_data = 16'h1001; tick();
    ext_out_ready = 1'b1;
    for (int k = 2; k < 16; k++) begin
      cpu_out_data = 16'(32'h1000 + k);
      chk_head($sformatf("stream%0d", k), 16'(32'h1000 + k - 2));
      tick();
      check("stream_ovf", 32'(err_out_ovf), 32'd0);
    end
    cpu_out_we = 1'b0;
    chk_head("stream_tail0", 16'h100E); tick();
    chk_head("stream_tail1", 16'h100F); tick();
    check("stream_empty", 32'(ext_out_valid), 32'd0);
    check("stream_unf", 32'(err_in_unf), 32'd0);
    ext_out_ready = 1'b0;

    // Input holding register
    ext_in_valid = 1'b1; ext_in_data = 16'hBEEF;
    tick();
    check("in_avail", 32'(cpu_in_avail), 32'd1);
    check("in_data", 32'(cpu_in_data), 32'h0000BEEF);
    check("in_ready_busy", 32'(ext_in_ready), 32'd0);
    ext_in_data = 16'h1234;
    tick();
    check("in_hold", 32'(cpu_in_data), 32'h0000BEEF);
    ext_in_valid = 1'b0; cpu_in_re = 1'b1;
    tick();
    check("rd_avail", 32'(cpu_in_avail), 32'd0);
    check("rd_data_kept", 32'(cpu_in_data), 32'h0000BEEF);
    check("rd_ready", 32'(ext_in_ready), 32'd1);
    check("rd_no_unf", 32'(err_in_unf), 32'd0);
    tick();
    check("unf_set", 32'(err_in_unf), 32'd1);
    check("unf_data_kept", 32'(cpu_in_data), 32'h0000BEEF);
    cpu_in_re = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1 || k == 10) begin
`ifdef IO_BRIDGE_STICKY_ERR_EN
        check($sformatf("unf_hold%0d", k), 32'(err_in_unf), 32'd1);
`else
        check($sformatf("unf_hold%0d", k), 32'(err_in_unf), 32'd0);
`endif
      end
    end
    err_clr = 1'b1;
    tick();
    check("unf_clr", 32'(err_in_unf), 32'd0);
    // Event together with err_clr keeps the flag set
    cpu_in_re = 1'b1;
    tick();
    check("unf_clr_evt", 32'(err_in_unf), 32'd1);
    cpu_in_re = 1'b0;
    tick();
    check("unf_clr2", 32'(err_in_unf), 32'd0);
    err_clr = 1'b0;

    // Mid-operation reset with FIFO holding 3 words and input loaded
    cpu_out_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_out_data = 16'(32'h2000 + i);
      tick();
    end
    cpu_out_we = 1'b0;
    ext_in_valid = 1'b1; ext_in_data = 16'h5555;
    tick();
    check("pre_rst_avail", 32'(cpu_in_avail), 32'd1);
    chk_head("pre_rst_head", 16'h2000);
    reset = 1'b1; cpu_out_we = 1'b1; ext_out_ready = 1'b1; cpu_in_re = 1'b1;
    tick();
    check("mid_rst_valid", 32'(ext_out_valid), 32'd0);
    check("mid_rst_avail", 32'(cpu_in_avail), 32'd0);
    check("mid_rst_in_data", 32'(cpu_in_data), 32'd0);
    check("mid_rst_ready", 32'(ext_in_ready), 32'd0);
    reset = 1'b0; cpu_out_we = 1'b0; ext_out_ready = 1'b0; cpu_in_re = 1'b0;
    ext_in_valid = 1'b0;
    tick();
    check("post_rst_valid", 32'(ext_out_valid), 32'd0);
    check("post_rst_avail", 32'(cpu_in_avail), 32'd0);
    check("post_rst_ready", 32'(ext_in_ready), 32'd1);
    check("post_rst_ovf", 32'(err_out_ovf), 32'd0);
    check("post_rst_unf", 32'(err_in_unf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_port_bridge.md
# io_port_bridge

Bridges the accumulator processor's 16-bit I/O registers to the outside world. It sits directly at the processor's I/O boundary. Processor output-port writes go into a small output FIFO that drains over a valid/ready handshake. External input words are captured into a single holding register, and the processor reads that register as its input-port value. The processor side never stalls: misuse is reported through error flags.

## Interface
- WIDTH, 16, data word width (matches processor datapath)
- DEPTH, 4, output FIFO entries; power of two, ≥2
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- cpu_out_we  in  1  processor writes cpu_out_data to output port this cycle
- cpu_out_data  in  WIDTH  processor output register value
- cpu_in_re  in  1  processor consumes the input word this cycle
- cpu_in_data  out  WIDTH  held input word (registered)
- cpu_in_avail  out  1  holding register contains an unread word
- ext_out_valid  out  1  FIFO head valid
- ext_out_data  out  WIDTH  FIFO head word
- ext_out_ready  in  1  external sink accepts head this cycle
- ext_in_valid  in  1  external source offers ext_in_data
- ext_in_data  in  WIDTH  external input word
- ext_in_ready  out  1  holding register can accept
- err_clr  in  1  clears sticky error flags (used only in sticky build)
- err_out_ovf  out  1  processor write dropped, FIFO full
- err_in_unf  out  1  processor read with no word available

## Operation
- Output FIFO: circular buffer, read/write pointers of log2(DEPTH) bits, wrap modulo DEPTH; count register 0..DEPTH.
- Push = cpu_out_we && (count<DEPTH || pop). Pop = ext_out_valid && ext_out_ready.
- Push and pop in the same cycle: both occur, count unchanged. This includes the full case, where the write is accepted.
- Push when full without pop: word dropped; pointers and count unchanged; overflow event.
- ext_out_valid = (count≠0); ext_out_data = mem[rd_ptr] (first-word fall-through, no bypass of an empty FIFO).
- ext_out_data is held stable while valid && !ready.
- Input path: ext_in_ready = !cpu_in_avail && !reset.
- Transfer when ext_in_valid && ext_in_ready: cpu_in_data <= ext_in_data, cpu_in_avail <= 1.
- cpu_in_re with avail=1: avail <= 0; cpu_in_data retains its value.
- cpu_in_re with avail=0: no state change; cpu_in_data unchanged (last value); underflow event.
- A new transfer and a read can never coincide, because ready is low while avail is high.

## Timing
- Reset values (after the first clocked reset edge): count=0, pointers=0, ext_out_valid=0, cpu_in_avail=0, cpu_in_data=0, err_out_ovf=0, err_in_unf=0. ext_in_ready=0 while reset is high.
- FIFO latency: push at edge N → ext_out_valid=1 after edge N. Pop at edge N → next head visible after edge N.
- Input latency: transfer at edge N → cpu_in_avail=1 and data after edge N. Read at edge N → ext_in_ready=1 after edge N.
- Error events are registered and appear after the offending edge.
- Reset asserted mid-operation discards FIFO contents and the held word. Reset overrides all simultaneous pushes, pops, transfers and err_clr.
- Full throughput: one push and one pop per cycle sustained indefinitely.

## Configuration
- IO_BRIDGE_STICKY_ERR_EN defined: error flags are sticky. Each flag sets on its event and stays set until reset or err_clr. If err_clr and a new event occur in the same cycle, the flag stays set.
- Not defined: each flag is a one-cycle pulse, high for exactly the cycle after each event. err_clr is ignored.

## Test plan
- Reset, then push 0x0001..0x0004 with ext_out_ready=0 → count=4, ext_out_data=0x0001; a 5th write of 0x0005 → dropped, err_out_ovf=1.
- Full FIFO, cpu_out_we=1 (0x00AA) with ext_out_ready=1 the same cycle → 0x0001 popped, 0x00AA accepted, count stays 4; draining yields 0x0002,0x0003,0x0004,0x00AA.
- Continuous push/pop of 0x1000..0x100F with ready=1 → output order is preserved across pointer wrap, with no errors.
- ext_in_valid=1, data 0xBEEF → cpu_in_avail=1, ext_in_ready=0 the next cycle. cpu_in_re → avail=0, cpu_in_data still 0xBEEF. A second cpu_in_re → err_in_unf asserted.
- Sticky build: trigger an underflow, wait 10 cycles → flag still 1; assert err_clr → 0. Non-sticky build: the same stimulus → flag high for one cycle only.
- Fill the FIFO with 3 words and load the input register, then assert reset for one cycle → all outputs at their reset values and ext_in_ready=1 the next cycle.
